// File: rtl/l1_l2_arb_pkg.sv
// l1_l2_arb_pkg: shared FSM state, owner and operation encodings for the L1->L2 request arbiter.
package l1_l2_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;
endpackage

// File: rtl/l1_l2_req_arbiter_if.sv
// l1_l2_req_arbiter_if: L1I/L1D request handshakes and the shared L2 request port.
interface l1_l2_req_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_grant;
    logic              i_resp;
    logic [LINE_W-1:0] i_rdata;
    logic              d_req;
    logic              d_write;
    logic              d_lock;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic              d_grant;
    logic              d_resp;
    logic [LINE_W-1:0] d_rdata;
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_addr;
    logic [LINE_W-1:0] l2_wdata;
    logic              l2_ready;
    logic [LINE_W-1:0] l2_rdata;
    modport slave (
        input  i_req, i_addr, d_req, d_write, d_lock, d_addr, d_wdata, l2_ready, l2_rdata,
        output i_grant, i_resp, i_rdata, d_grant, d_resp, d_rdata, l2_read, l2_write, l2_addr, l2_wdata
    );
    modport master (
        output i_req, i_addr, d_req, d_write, d_lock, d_addr, d_wdata, l2_ready, l2_rdata,
        input  i_grant, i_resp, i_rdata, d_grant, d_resp, d_rdata, l2_read, l2_write, l2_addr, l2_wdata
    );
endinterface

// File: rtl/rr_pick2.sv
// rr_pick2: two-way combinational picker; pointer names the preferred side, force_d overrides it.
module rr_pick2
    import l1_l2_arb_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic ptr,
    input  logic force_d,
    output logic gnt_i,
    output logic gnt_d
);
    always_comb begin
        gnt_d = req_d & (~req_i | (ptr == OWN_D) | force_d);
        gnt_i = req_i & ~gnt_d;
    end
endmodule

// File: rtl/l1_l2_req_arbiter.sv
// l1_l2_req_arbiter: round-robin L1I/L1D arbiter onto the single L2 request port,
// with an L1D write-back->refill lock and a sticky watchdog on hung L2 transactions.
module l1_l2_req_arbiter
    import l1_l2_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                nrst,
    l1_l2_req_arbiter_if.slave  bus,
    output logic                timeout_err
);
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              op_q, op_d;
    logic              ptr_q, ptr_d;
    logic              lock_q, lock_d;
    logic              terr_q, terr_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
    logic              idle, gnt_i, gnt_d;
    logic [LINE_W-1:0] fill;

    // Grants are only offered in IDLE and are masked while reset is held.
    assign idle = (state_q == IDLE) & nrst;

    rr_pick2 u_pick (
        .req_i   (bus.i_req & idle),
        .req_d   (bus.d_req & idle),
        .ptr     (ptr_q),
        .force_d (lock_q),
        .gnt_i   (gnt_i),
        .gnt_d   (gnt_d)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        op_d      = op_q;
        ptr_d     = ptr_q;
        lock_d    = lock_q;
        terr_d    = terr_q;
        wd_d      = '0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        fill      = bus.l2_ready ? bus.l2_rdata : '0;
        case (state_q)
            IDLE: if (gnt_i | gnt_d) begin
                state_d = BUSY;
                owner_d = gnt_d ? OWN_D : OWN_I;
                op_d    = (gnt_d & bus.d_write) ? OP_WR : OP_RD;
                addr_d  = gnt_d ? bus.d_addr : bus.i_addr;
                wdata_d = gnt_d ? bus.d_wdata : wdata_q;
                ptr_d   = gnt_d ? OWN_I : OWN_D;
                lock_d  = gnt_d & bus.d_lock;
            end
            BUSY: begin
                wd_d = wd_q + 1'b1;
                // A hung transaction completes as a zero-data fill so the requester unblocks.
                if (bus.l2_ready || wd_q == WD_MAX) begin
                    state_d   = RESP;
                    wd_d      = '0;
                    terr_d    = terr_q | ~bus.l2_ready;
                    i_rdata_d = (op_q == OP_RD && owner_q == OWN_I) ? fill : i_rdata_q;
                    d_rdata_d = (op_q == OP_RD && owner_q == OWN_D) ? fill : d_rdata_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            op_q      <= OP_RD;
            ptr_q     <= OWN_D;
            lock_q    <= 1'b0;
            terr_q    <= 1'b0;
            wd_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            op_q      <= op_d;
            ptr_q     <= ptr_d;
            lock_q    <= lock_d;
            terr_q    <= terr_d;
            wd_q      <= wd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign bus.i_grant  = gnt_i;
    assign bus.d_grant  = gnt_d;
    assign bus.i_resp   = (state_q == RESP) & (owner_q == OWN_I);
    assign bus.d_resp   = (state_q == RESP) & (owner_q == OWN_D);
    assign bus.i_rdata  = i_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.l2_read  = (state_q == BUSY) & (op_q == OP_RD);
    assign bus.l2_write = (state_q == BUSY) & (op_q == OP_WR);
    assign bus.l2_addr  = addr_q;
    assign bus.l2_wdata = wdata_q;
    assign timeout_err  = terr_q;
endmodule

// File: tb/tb_l1_l2_req_arbiter.sv
// tb_l1_l2_req_arbiter: directed and randomized transactions checked against a
// transaction-level model of the arbitration, lock, latency and watchdog rules.
module tb_l1_l2_req_arbiter;
    localparam int AW = 32;
    localparam int LW = 128;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic timeout_err;
    always #5 clk = ~clk;

    l1_l2_req_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();
    l1_l2_req_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .bus         (bus),
        .timeout_err (timeout_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    // model: who is preferred next, lock, sticky error, and what each requester last received
    bit m_ptr_d = 1'b1;
    bit m_lock = 1'b0;
    bit m_terr = 1'b0;
    logic [LW-1:0] m_i_rd = '0;
    logic [LW-1:0] m_d_rd = '0;

    // requests currently held by the two L1 controllers
    bit i_p = 1'b0, d_p = 1'b0, d_w = 1'b0, d_l = 1'b0;
    logic [AW-1:0] i_a = '0, d_a = '0;
    logic [LW-1:0] d_wd = '0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pending();
        bus.i_req   = i_p;
        bus.i_addr  = i_a;
        bus.d_req   = d_p;
        bus.d_write = d_w;
        bus.d_lock  = d_l;
        bus.d_addr  = d_a;
        bus.d_wdata = d_wd;
    endtask

    task automatic model_reset();
        m_ptr_d = 1'b1;
        m_lock  = 1'b0;
        m_terr  = 1'b0;
        m_i_rd  = '0;
        m_d_rd  = '0;
    endtask

    // One full transaction starting in an IDLE cycle: grant, lat+1 strobe cycles
    // (or TO cycles when L2 hangs), then the resp cycle with a spurious l2_ready.
    task automatic round(input int lat, input bit hang, input logic [LW-1:0] rd);
        bit w_d, wr;
        logic [AW-1:0] a;
        logic [LW-1:0] wd;
        int busy_n;
        w_d = d_p && (!i_p || m_ptr_d || m_lock);
        wr = w_d && d_w;
        a = w_d ? d_a : i_a;
        wd = d_wd;
        busy_n = hang ? TO : lat + 1;
        drive_pending();
        bus.l2_ready = 1'b0;
        #3;
        chk("i_grant", LW'(bus.i_grant), LW'(!w_d));
        chk("d_grant", LW'(bus.d_grant), LW'(w_d));
        chk("strobe_at_grant", LW'({bus.l2_read, bus.l2_write}), '0);
        chk("terr_at_grant", LW'(timeout_err), LW'(m_terr));
        m_ptr_d = !w_d;
        m_lock = w_d && d_l;
        for (int k = 0; k < busy_n; k++) begin
            tick();
            bus.d_write  = 1'($urandom);
            bus.d_lock   = 1'($urandom);
            bus.d_addr   = $urandom;
            bus.i_addr   = $urandom;
            bus.d_wdata  = {4{$urandom}};
            bus.l2_ready = !hang && k == lat;
            bus.l2_rdata = (k == lat) ? rd : {4{$urandom}};
            #3;
            chk("l2_read", LW'(bus.l2_read), LW'(!wr));
            chk("l2_write", LW'(bus.l2_write), LW'(wr));
            chk("l2_addr", LW'(bus.l2_addr), LW'(a));
            if (wr) chk("l2_wdata", bus.l2_wdata, wd);
            chk("grant_in_busy", LW'({bus.i_grant, bus.d_grant}), '0);
            chk("resp_in_busy", LW'({bus.i_resp, bus.d_resp}), '0);
            chk("terr_in_busy", LW'(timeout_err), LW'(m_terr));
        end
        if (!wr) begin
            if (w_d) m_d_rd = hang ? '0 : rd;
            else m_i_rd = hang ? '0 : rd;
        end
        if (hang) m_terr = 1'b1;
        tick();
        bus.l2_ready = 1'($urandom);
        bus.l2_rdata = {4{$urandom}};
        #3;
        chk("i_resp", LW'(bus.i_resp), LW'(!w_d));
        chk("d_resp", LW'(bus.d_resp), LW'(w_d));
        chk("i_rdata", bus.i_rdata, m_i_rd);
        chk("d_rdata", bus.d_rdata, m_d_rd);
        chk("strobe_in_resp", LW'({bus.l2_read, bus.l2_write}), '0);
        chk("grant_in_resp", LW'({bus.i_grant, bus.d_grant}), '0);
        chk("terr_in_resp", LW'(timeout_err), LW'(m_terr));
        tick();
        bus.l2_ready = 1'b0;
        if (w_d) d_p = 1'b0;
        else i_p = 1'b0;
    endtask

    initial begin
        bus.i_req = 1'b1; bus.i_addr = '0; bus.d_req = 1'b1; bus.d_write = 1'b0;
        bus.d_lock = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.l2_ready = 1'b0; bus.l2_rdata = '0;
        #3;
        chk("rst_grants", LW'({bus.i_grant, bus.d_grant}), '0);
        chk("rst_resps", LW'({bus.i_resp, bus.d_resp}), '0);
        chk("rst_strobes", LW'({bus.l2_read, bus.l2_write}), '0);
        chk("rst_l2_addr", LW'(bus.l2_addr), '0);
        chk("rst_rdata", bus.i_rdata | bus.d_rdata, '0);
        chk("rst_terr", LW'(timeout_err), '0);
        tick();
        tick();
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        nrst = 1'b1;
        tick();

        // contention: both held continuously, expect strict alternation starting with L1D
        i_p = 1'b1; i_a = $urandom; d_p = 1'b1; d_a = $urandom; d_wd = {4{$urandom}};
        for (int r = 0; r < 4; r++) begin
            round($urandom_range(0, 3), 1'b0, {4{$urandom}});
            if (!i_p) begin i_p = 1'b1; i_a = $urandom; end
            if (!d_p) begin d_p = 1'b1; d_a = $urandom; end
        end
        i_p = 1'b0; d_p = 1'b0;

        // single fill, ready on the 4th strobe cycle
        i_p = 1'b1; i_a = 32'h0000_0040;
        round(3, 1'b0, {16{8'hA5}});

        // locked write-back, then its refill ahead of the waiting L1I
        i_p = 1'b1; i_a = 32'h0000_3000;
        d_p = 1'b1; d_w = 1'b1; d_l = 1'b1; d_a = 32'h100; d_wd = {4{$urandom}};
        round(2, 1'b0, {4{$urandom}});
        d_p = 1'b1; d_w = 1'b0; d_l = 1'b0; d_a = 32'h200;
        round(1, 1'b0, {4{$urandom}});
        round(0, 1'b0, {4{$urandom}});

        // watchdog: L2 never answers an L1D fill, then normal service resumes
        d_p = 1'b1; d_w = 1'b0; d_l = 1'b0; d_a = 32'h400;
        round(0, 1'b1, '0);
        i_p = 1'b1; i_a = 32'h500;
        round(2, 1'b0, {4{$urandom}});

        // spurious l2_ready while IDLE
        drive_pending();
        bus.l2_ready = 1'b1;
        bus.l2_rdata = {4{$urandom}};
        #3;
        chk("spur_grants", LW'({bus.i_grant, bus.d_grant}), '0);
        chk("spur_strobes", LW'({bus.l2_read, bus.l2_write}), '0);
        tick();
        bus.l2_ready = 1'b0;
        #3;
        chk("spur_resps", LW'({bus.i_resp, bus.d_resp}), '0);
        chk("spur_strobes2", LW'({bus.l2_read, bus.l2_write}), '0);
        chk("spur_i_rdata", bus.i_rdata, m_i_rd);
        chk("spur_d_rdata", bus.d_rdata, m_d_rd);
        tick();

        // randomized traffic
        for (int r = 0; r < 30; r++) begin
            if (!i_p && $urandom_range(0, 1) == 1) begin i_p = 1'b1; i_a = $urandom; end
            if (!d_p && $urandom_range(0, 1) == 1) begin
                d_p = 1'b1; d_w = 1'($urandom); d_l = 1'($urandom);
                d_a = $urandom; d_wd = {4{$urandom}};
            end
            if (!i_p && !d_p) begin i_p = 1'b1; i_a = $urandom; end
            round($urandom_range(0, 4), 1'b0, {4{$urandom}});
        end

        // async reset in the middle of a read
        d_p = 1'b0; i_p = 1'b1; i_a = 32'h0000_7700;
        drive_pending();
        #3;
        chk("ar_grant", LW'({bus.i_grant, bus.d_grant}), LW'(2'b10));
        tick();
        #3;
        chk("ar_read_before", LW'(bus.l2_read), LW'(1));
        #1;
        nrst = 1'b0;
        #1;
        chk("ar_read_dropped", LW'(bus.l2_read), '0);
        chk("ar_addr_cleared", LW'(bus.l2_addr), '0);
        model_reset();
        for (int k = 0; k < 2; k++) begin
            tick();
            #3;
            chk("ar_no_resp", LW'({bus.i_resp, bus.d_resp}), '0);
            chk("ar_no_grant", LW'({bus.i_grant, bus.d_grant}), '0);
            chk("ar_terr", LW'(timeout_err), '0);
        end
        tick();
        i_p = 1'b0;
        drive_pending();
        nrst = 1'b1;
        tick();
        i_p = 1'b1; i_a = $urandom;
        d_p = 1'b1; d_w = 1'b0; d_l = 1'b0; d_a = $urandom;
        round(1, 1'b0, {4{$urandom}});
        round(1, 1'b0, {4{$urandom}});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/l1_l2_req_arbiter.md
Name: l1_l2_req_arbiter

Overview:
- Arbitrates line-fill and write-back requests from the L1I and L1D cache controllers onto the single shared L2 request port.
- Provides round-robin fairness, a lock so an L1D write-back can be followed directly by its refill, and a sticky watchdog error on a hung L2 transaction.
- Sits between the L1I/L1D miss handlers and the L2 controller, all in the memory clock domain.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 128, L1 line width in bits (read and write data).
- TIMEOUT, 1024, max cycles in BUSY before the watchdog fires; must be ≥2.

Ports:
- clk  in  1  memory-domain clock.
- nrst  in  1  reset; asynchronous, active-low.
- i_req  in  1  L1I request; level, held until i_resp.
- i_addr  in  ADDR_W  L1I line address.
- i_grant  out  1  one-cycle pulse when L1I request is accepted.
- i_resp  out  1  one-cycle pulse; i_rdata is valid.
- i_rdata  out  LINE_W  fill data.
- d_req  in  1  L1D request; level, held until d_resp.
- d_write  in  1  1 = write-back, 0 = fill; sampled with d_req.
- d_lock  in  1  keep grant for the next L1D request; sampled with d_req.
- d_addr  in  ADDR_W  L1D line address.
- d_wdata  in  LINE_W  write-back data.
- d_grant  out  1  one-cycle pulse when L1D request is accepted.
- d_resp  out  1  one-cycle pulse: fill data valid, or write done.
- d_rdata  out  LINE_W  fill data.
- l2_read  out  1  level read strobe to L2.
- l2_write  out  1  level write strobe to L2.
- l2_addr  out  ADDR_W  registered request address.
- l2_wdata  out  LINE_W  registered write data.
- l2_ready  in  1  L2 completion pulse.
- l2_rdata  in  LINE_W  L2 read data, valid with l2_ready.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, nrst=0): state IDLE, all outputs 0, priority pointer = L1D, lock clear, watchdog = 0, timeout_err = 0. Deassertion takes effect on the next clk edge. Reset mid-transaction drops l2_read/l2_write immediately and abandons the transaction; no resp is issued.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Only L1I requesting → grant L1I.
  - Only L1D requesting → grant L1D.
  - Both requesting → grant the pointer owner, except lock=1 forces L1D.
  - On grant (cycle N): pulse x_grant; register owner, addr, wdata, and op (L1I always read); go to BUSY.
- Pointer: after each grant, points to the other requester.
- Lock: set when L1D is granted with d_lock=1. Cleared on the next IDLE arbitration, whether or not L1D wins it.
- BUSY:
  - l2_read = ~op, l2_write = op; l2_addr/l2_wdata held stable. Strobes are first visible in cycle N+1.
  - l2_ready=1 → capture l2_rdata into owner's rdata register (reads only), drop strobes, go to RESP.
  - Watchdog increments each BUSY cycle and clears on leaving BUSY. If it reaches TIMEOUT-1 with no l2_ready: set timeout_err, go to RESP, deliver rdata = 0 so the requester unblocks.
- RESP: x_resp pulses for one cycle; rdata holds until the next capture. Next state is IDLE. Requests are not sampled in RESP, so a requester's level held through the resp cycle is not re-granted.
- Latency: grant at N, strobe at N+1, resp one cycle after l2_ready. Minimum 3 cycles request-to-resp (l2_ready at N+1).
- Ignored inputs:
  - l2_ready outside BUSY is ignored.
  - d_write/d_lock/addr changes while BUSY are ignored (values are registered).
- Never both l2_read and l2_write; never both grants or both resps in one cycle.
- timeout_err clears only on reset.

Decomposition:
- Package l1_l2_arb_pkg: state enum (IDLE/BUSY/RESP), owner constants OWN_I=0 / OWN_D=1, op constants OP_RD / OP_WR.
- Sub-module rr_pick2: combinational two-way picker with priority pointer and force-D input, so it can be tested exhaustively in isolation.
- Watchdog counter stays inline.

Test Plan:
- Single fill: i_req=1, addr 0x0000_0040; L2 returns l2_ready 4 cycles after strobe with rdata 0xA5..A5 → i_grant at N, l2_read N+1..N+4, i_resp at N+5 with i_rdata = 0xA5..A5, l2_write never high.
- Contention: i_req and d_req both rise the cycle after reset → L1D granted first (pointer reset), L1I second, alternating over 4 back-to-back rounds.
- Locked write-back: d_write=1, d_lock=1, addr 0x100 with i_req also pending; then d_req (fill) 0x200 in the IDLE cycle after RESP → write 0x100, then read 0x200, then the L1I request; l2_wdata matches d_wdata during the write.
- Watchdog: TIMEOUT=8, never assert l2_ready → timeout_err rises after 8 BUSY cycles, d_resp pulses with d_rdata = 0, FSM returns to IDLE, and the next request is served normally.
- Async reset: pull nrst low mid-BUSY with l2_read=1 → l2_read falls without a clock edge, no resp is issued, and after release the first grant goes to L1D.
- Spurious ready: l2_ready pulsed in IDLE and in RESP → no state change, no resp, rdata unchanged.
